// File: rtl/lsu_axi_master.sv
// ---------------------------------------------------------------------------
// lsu_axi_master
//
// Load/store bus initiator for the multicycle core. It accepts one load or
// store at a time from the EXU/MEM stage, drives the AXI-lite-style mem_*
// channels toward the memory responder, and returns the extended load data
// (or zero for stores) together with an error flag.
//
// The responder always works on whole 32-bit words. Byte-lane placement of
// store data, write-strobe generation and extraction/extension of load data
// all happen in this unit.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready request handshake; req_ready is high only when idle
//   req_wen             1 = store, 0 = load
//   req_op              0=b, 1=h, 2=w, 4=bu, 5=hu (stores use 0/1/2)
//   req_addr            byte address
//   req_wdata           store data, LSB-justified
//   resp_valid/ready    result handshake
//   resp_rdata          extended load data, 0 for stores
//   resp_err            misaligned access or non-zero rresp/bresp
//   mem_ar*, mem_r*     read address / read data channels
//   mem_aw*, mem_w*     write address / write data channels
//   mem_b*              write response channel
// ---------------------------------------------------------------------------
module lsu_axi_master #(
    parameter int ADDR_W = 32,
    parameter int STRB_W = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,

    output logic [ADDR_W-1:0] mem_araddr,
    output logic              mem_arvalid,
    input  logic              mem_arready,

    input  logic [31:0]       mem_rdata,
    input  logic [1:0]        mem_rresp,
    input  logic              mem_rvalid,
    output logic              mem_rready,

    output logic [ADDR_W-1:0] mem_awaddr,
    output logic              mem_awvalid,
    input  logic              mem_awready,

    output logic [31:0]       mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic              mem_wvalid,
    input  logic              mem_wready,

    input  logic [1:0]        mem_bresp,
    input  logic              mem_bvalid,
    output logic              mem_bready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;

    // Request fields latched at accept; req_* may change afterwards.
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        op_q;
    logic [31:0]       wdata_q;
    logic [3:0]        strb_q;

    // Per-channel completion flags for the write address and data channels,
    // which may handshake in different cycles.
    logic aw_done_q;
    logic w_done_q;

    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    // FSM strobes that steer the datapath registers.
    logic accept;
    logic take_rdata;
    logic take_bresp;

    logic        req_misaligned;
    logic [3:0]  req_strb;
    logic [31:0] req_wdata_lane;
    logic [31:0] rdata_shifted;
    logic [31:0] load_data;
    logic        aw_hs;
    logic        w_hs;
    logic        aw_fin;
    logic        w_fin;

    // Access size decode: op[1] selects word, otherwise op[0] selects half,
    // else byte. op[2] only matters for load extension.
    always_comb begin
        req_misaligned = 1'b0;
        req_strb       = 4'b0001 << req_addr[1:0];
        if (req_op[1]) begin
            req_misaligned = |req_addr[1:0];
            req_strb       = 4'b1111;
        end else if (req_op[0]) begin
            req_misaligned = req_addr[0];
            req_strb       = 4'b0011 << req_addr[1:0];
        end
    end

    assign req_wdata_lane = req_wdata << {req_addr[1:0], 3'b000};

    // The responder returns the full word; bring the addressed byte/half down
    // to bit 0 and then extend it according to the latched op.
    assign rdata_shifted = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_data = rdata_shifted;
        case (op_q)
            3'h0:    load_data = {{24{rdata_shifted[7]}},  rdata_shifted[7:0]};
            3'h1:    load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'h4:    load_data = {24'h000000, rdata_shifted[7:0]};
            3'h5:    load_data = {16'h0000,   rdata_shifted[15:0]};
            default: load_data = rdata_shifted;
        endcase
    end

    assign aw_hs  = mem_awvalid & mem_awready;
    assign w_hs   = mem_wvalid & mem_wready;
    assign aw_fin = aw_done_q | aw_hs;
    assign w_fin  = w_done_q | w_hs;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        take_rdata = 1'b0;
        take_bresp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (req_misaligned) begin
                        state_d = RESP;
                    end else if (req_wen) begin
                        state_d = WR_REQ;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (mem_arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (mem_rvalid) begin
                    take_rdata = 1'b1;
                    state_d    = RESP;
                end
            end
            WR_REQ: begin
                // A write response arriving together with the last of the
                // aw/w handshakes is taken here without visiting WR_RESP.
                if (aw_fin && w_fin) begin
                    if (mem_bvalid) begin
                        take_bresp = 1'b1;
                        state_d    = RESP;
                    end else begin
                        state_d = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (mem_bvalid) begin
                    take_bresp = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latch and write-channel completion tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            op_q      <= 3'h0;
            wdata_q   <= 32'h0;
            strb_q    <= 4'h0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (accept) begin
            addr_q    <= req_addr;
            op_q      <= req_op;
            wdata_q   <= req_wdata_lane;
            strb_q    <= req_strb;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (state_q == WR_REQ) begin
            if (aw_hs) begin
                aw_done_q <= 1'b1;
            end
            if (w_hs) begin
                w_done_q <= 1'b1;
            end
        end
    end

    // Result registers. A misaligned request reports its error directly from
    // the accept; bus transactions overwrite them when their response lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else if (accept) begin
            resp_rdata_q <= 32'h0;
            resp_err_q   <= req_misaligned;
        end else if (take_rdata) begin
            resp_rdata_q <= load_data;
            resp_err_q   <= |mem_rresp;
        end else if (take_bresp) begin
            resp_rdata_q <= 32'h0;
            resp_err_q   <= |mem_bresp;
        end
    end

    // Handshake outputs are pure state decodes, so they never depend on a
    // ready input and fall to zero as soon as reset forces IDLE. req_ready is
    // also gated by rst so nothing looks acceptable while reset is held.
    assign req_ready   = rst & (state_q == IDLE);
    assign resp_valid  = (state_q == RESP);
    assign mem_arvalid = (state_q == RD_REQ);
    assign mem_rready  = (state_q == RD_REQ) | (state_q == RD_DATA);
    assign mem_awvalid = (state_q == WR_REQ) & ~aw_done_q;
    assign mem_wvalid  = (state_q == WR_REQ) & ~w_done_q;
    assign mem_bready  = (state_q == WR_REQ) | (state_q == WR_RESP);

    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign mem_araddr  = addr_q;
    assign mem_awaddr  = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_wstrb   = STRB_W'(strb_q);

endmodule

// File: tb/tb_lsu_axi_master.sv
// ---------------------------------------------------------------------------
// tb_lsu_axi_master
//
// Directed bench for lsu_axi_master. The bench plays both the core and the
// memory responder; expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_lsu_axi_master;

    localparam int ADDR_W = 32;
    localparam int STRB_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_araddr;
    logic              mem_arvalid;
    logic              mem_arready;
    logic [31:0]       mem_rdata;
    logic [1:0]        mem_rresp;
    logic              mem_rvalid;
    logic              mem_rready;
    logic [ADDR_W-1:0] mem_awaddr;
    logic              mem_awvalid;
    logic              mem_awready;
    logic [31:0]       mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_wvalid;
    logic              mem_wready;
    logic [1:0]        mem_bresp;
    logic              mem_bvalid;
    logic              mem_bready;

    int checkCount = 0;
    int errorCount = 0;
    int arCount = 0;
    int awCount = 0;

    lsu_axi_master #(.ADDR_W(ADDR_W), .STRB_W(STRB_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
        .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid),
        .mem_rready(mem_rready),
        .mem_awaddr(mem_awaddr), .mem_awvalid(mem_awvalid), .mem_awready(mem_awready),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wvalid(mem_wvalid),
        .mem_wready(mem_wready),
        .mem_bresp(mem_bresp), .mem_bvalid(mem_bvalid), .mem_bready(mem_bready)
    );

    always #5 clk = ~clk;

    // Count address-channel valid cycles so tests can prove no bus activity.
    always @(posedge clk) begin
        if (mem_arvalid) arCount++;
        if (mem_awvalid) awCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Present one request for a single cycle, then scramble req_* to show the
    // unit works from its latched copy.
    task automatic applyStimulus(input logic wen, input logic [2:0] op,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_wen   = wen;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_wen   = ~wen;
        req_op    = 3'h3;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h5A5A_5A5A;
    endtask

    // Responder for a read: hold off arready for waitCycles, then return word.
    task automatic serveRead(input int waitCycles, input logic [31:0] word,
                             input logic [1:0] rresp, input logic [31:0] expAddr);
        checkOutput("arvalid_asserted", 32'(mem_arvalid), 32'd1);
        checkOutput("rready_with_ar", 32'(mem_rready), 32'd1);
        checkOutput("araddr", mem_araddr, expAddr);
        for (int i = 0; i < waitCycles; i++) begin
            @(negedge clk);
            checkOutput("arvalid_held", 32'(mem_arvalid), 32'd1);
        end
        mem_arready = 1'b1;
        @(negedge clk);
        mem_arready = 1'b0;
        checkOutput("arvalid_dropped", 32'(mem_arvalid), 32'd0);
        checkOutput("rready_kept", 32'(mem_rready), 32'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        mem_rresp  = rresp;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rresp  = 2'b00;
        mem_rdata  = 32'hBADB_ADBA;
    endtask

    // Responder for a write: awready/wready pulse at their own delays; bvalid
    // either coincides with the last handshake or follows one cycle later.
    task automatic serveWrite(input int awDelay, input int wDelay, input logic bWithLast,
                              input logic [1:0] bresp, input logic [31:0] expAddr,
                              input logic [31:0] expData, input logic [7:0] expStrb);
        int last;
        last = (awDelay > wDelay) ? awDelay : wDelay;
        checkOutput("awaddr", mem_awaddr, expAddr);
        checkOutput("wdata", mem_wdata, expData);
        checkOutput("wstrb", 32'(mem_wstrb), 32'(expStrb));
        checkOutput("bready_with_aw", 32'(mem_bready), 32'd1);
        for (int c = 0; c <= last; c++) begin
            checkOutput("awvalid_phase", 32'(mem_awvalid), 32'(c <= awDelay));
            checkOutput("wvalid_phase", 32'(mem_wvalid), 32'(c <= wDelay));
            mem_awready = (c == awDelay);
            mem_wready  = (c == wDelay);
            if (bWithLast && c == last) begin
                mem_bvalid = 1'b1;
                mem_bresp  = bresp;
            end
            @(negedge clk);
        end
        mem_awready = 1'b0;
        mem_wready  = 1'b0;
        if (!bWithLast) begin
            checkOutput("bready_held", 32'(mem_bready), 32'd1);
            checkOutput("awvalid_idle_wresp", 32'(mem_awvalid), 32'd0);
            checkOutput("wvalid_idle_wresp", 32'(mem_wvalid), 32'd0);
            checkOutput("resp_valid_before_b", 32'(resp_valid), 32'd0);
            mem_bvalid = 1'b1;
            mem_bresp  = bresp;
            @(negedge clk);
        end
        mem_bvalid = 1'b0;
        mem_bresp  = 2'b00;
    endtask

    // Wait (bounded) for the result, optionally stall it while offering a
    // competing request, acknowledge, and confirm a single pulse.
    task automatic waitResp(input logic [31:0] expData, input logic expErr, input int holdCycles);
        int n;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("resp_valid", 32'(resp_valid), 32'd1);
        checkOutput("resp_rdata", resp_rdata, expData);
        checkOutput("resp_err", 32'(resp_err), 32'(expErr));
        if (holdCycles > 0) begin
            req_valid = 1'b1;
            req_wen   = 1'b0;
            req_op    = 3'h2;
            req_addr  = 32'h8000_0100;
            for (int i = 0; i < holdCycles; i++) begin
                @(negedge clk);
                checkOutput("hold_resp_valid", 32'(resp_valid), 32'd1);
                checkOutput("hold_resp_rdata", resp_rdata, expData);
                checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        checkOutput("req_ready_back", 32'(req_ready), 32'd1);
        for (int i = 0; i < 2; i++) begin
            checkOutput("resp_single_pulse", 32'(resp_valid), 32'd0);
            checkOutput("no_stray_ar", 32'(mem_arvalid), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        int base;
        req_valid   = 1'b0;
        req_wen     = 1'b0;
        req_op      = 3'h0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        resp_ready  = 1'b0;
        mem_arready = 1'b0;
        mem_rdata   = 32'h0;
        mem_rresp   = 2'b00;
        mem_rvalid  = 1'b0;
        mem_awready = 1'b0;
        mem_wready  = 1'b0;
        mem_bresp   = 2'b00;
        mem_bvalid  = 1'b0;

        #1;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_arvalid", 32'(mem_arvalid), 32'd0);
        checkOutput("rst_rready", 32'(mem_rready), 32'd0);
        checkOutput("rst_awvalid", 32'(mem_awvalid), 32'd0);
        checkOutput("rst_wvalid", 32'(mem_wvalid), 32'd0);
        checkOutput("rst_bready", 32'(mem_bready), 32'd0);
        checkOutput("rst_wstrb", 32'(mem_wstrb), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("post_rst_req_ready", 32'(req_ready), 32'd1);

        $display("[TB] lw with five arready wait cycles");
        applyStimulus(1'b0, 3'h2, 32'h8000_0004, 32'h0);
        serveRead(5, 32'hDEAD_BEEF, 2'b00, 32'h8000_0004);
        waitResp(32'hDEAD_BEEF, 1'b0, 0);

        $display("[TB] byte/half loads with extension");
        applyStimulus(1'b0, 3'h0, 32'h8000_0003, 32'h0);
        serveRead(0, 32'h80FF_1234, 2'b00, 32'h8000_0003);
        waitResp(32'hFFFF_FF80, 1'b0, 0);
        applyStimulus(1'b0, 3'h4, 32'h8000_0003, 32'h0);
        serveRead(0, 32'h80FF_1234, 2'b00, 32'h8000_0003);
        waitResp(32'h0000_0080, 1'b0, 0);
        applyStimulus(1'b0, 3'h5, 32'h8000_0002, 32'h0);
        serveRead(0, 32'h80FF_1234, 2'b00, 32'h8000_0002);
        waitResp(32'h0000_80FF, 1'b0, 0);
        applyStimulus(1'b0, 3'h1, 32'h8000_0002, 32'h0);
        serveRead(0, 32'h80FF_1234, 2'b00, 32'h8000_0002);
        waitResp(32'hFFFF_80FF, 1'b0, 0);
        applyStimulus(1'b0, 3'h1, 32'h8000_0000, 32'h0);
        serveRead(0, 32'h80FF_1234, 2'b00, 32'h8000_0000);
        waitResp(32'h0000_1234, 1'b0, 0);

        $display("[TB] stores with lane shift and strobes");
        applyStimulus(1'b1, 3'h0, 32'h8000_0001, 32'h0000_00AB);
        serveWrite(0, 0, 1'b0, 2'b00, 32'h8000_0001, 32'h0000_AB00, 8'h02);
        waitResp(32'h0, 1'b0, 0);
        applyStimulus(1'b1, 3'h1, 32'h8000_0002, 32'h0000_1234);
        serveWrite(2, 0, 1'b1, 2'b00, 32'h8000_0002, 32'h1234_0000, 8'h0C);
        waitResp(32'h0, 1'b0, 0);

        $display("[TB] store with awready one cycle before wready");
        applyStimulus(1'b1, 3'h2, 32'h8000_0010, 32'hCAFE_F00D);
        serveWrite(0, 1, 1'b0, 2'b00, 32'h8000_0010, 32'hCAFE_F00D, 8'h0F);
        waitResp(32'h0, 1'b0, 0);

        $display("[TB] store with error bresp");
        applyStimulus(1'b1, 3'h2, 32'h8000_0014, 32'h0102_0304);
        serveWrite(1, 1, 1'b1, 2'b11, 32'h8000_0014, 32'h0102_0304, 8'h0F);
        waitResp(32'h0, 1'b1, 0);

        $display("[TB] misaligned accesses");
        base = arCount;
        applyStimulus(1'b0, 3'h2, 32'h8000_0002, 32'h0);
        waitResp(32'h0, 1'b1, 0);
        checkOutput("misaligned_lw_no_ar", 32'(arCount - base), 32'd0);
        base = awCount;
        applyStimulus(1'b1, 3'h1, 32'h8000_0001, 32'h0000_BEEF);
        waitResp(32'h0, 1'b1, 0);
        checkOutput("misaligned_sh_no_aw", 32'(awCount - base), 32'd0);

        $display("[TB] load with error rresp");
        applyStimulus(1'b0, 3'h2, 32'h8000_0020, 32'h0);
        serveRead(0, 32'h1122_3344, 2'b10, 32'h8000_0020);
        waitResp(32'h1122_3344, 1'b1, 0);

        $display("[TB] result stalled by resp_ready for ten cycles");
        applyStimulus(1'b0, 3'h2, 32'h8000_0024, 32'h0);
        serveRead(0, 32'h0BAD_F00D, 2'b00, 32'h8000_0024);
        base = arCount;
        waitResp(32'h0BAD_F00D, 1'b0, 10);
        checkOutput("stall_no_new_ar", 32'(arCount - base), 32'd0);

        $display("[TB] reset during RD_DATA");
        applyStimulus(1'b0, 3'h2, 32'h8000_0008, 32'h0);
        mem_arready = 1'b1;
        @(negedge clk);
        mem_arready = 1'b0;
        checkOutput("rd_data_rready", 32'(mem_rready), 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_rst_rready", 32'(mem_rready), 32'd0);
        checkOutput("async_rst_arvalid", 32'(mem_arvalid), 32'd0);
        checkOutput("async_rst_araddr", mem_araddr, 32'd0);
        checkOutput("async_rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("async_rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("release_req_ready", 32'(req_ready), 32'd1);

        $display("[TB] load after reset");
        applyStimulus(1'b0, 3'h2, 32'h8000_0004, 32'h0);
        serveRead(1, 32'h1234_5678, 2'b00, 32'h8000_0004);
        waitResp(32'h1234_5678, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
